// File: rtl/prio_enc_queue.sv
// Purpose: sticky request capture plus a one-entry registered grant slot, fixed-priority or round-robin.
// Latency: a request seen at edge t is pending after t and granted on out_code after edge t+1 if the slot is free.
// Backpressure: out_code/out_valid hold while out_ready is low, and requests keep accumulating in pending.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   en              capture enable for req; draining continues while low
//   req[N-1:0]      level-sampled request lines
//   out_valid/out_ready/out_code   granted index handshake
//   pending[N-1:0]  requests captured but not yet granted
//   any             pending non-empty or a grant is being offered
module prio_enc_queue #(
    parameter int N    = 8,
    parameter int W    = $clog2(N),
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_code,
    output logic [N-1:0] pending,
    output logic         any
);

    logic [W-1:0] ptr;
    logic [W-1:0] sel;
    logic [N-1:0] set_vec;
    logic [N-1:0] clr_vec;
    logic         slot_free;
    logic         load;

    assign slot_free = !out_valid || out_ready;
    assign load      = slot_free && (|pending);
    assign set_vec   = en ? req : '0;

    // Selection looks only at the registered pending vector, so a request
    // arriving this cycle can never be granted in the same cycle.
    always_comb begin
        sel = '0;
        if (MODE == 0) begin
            // Ascending scan: the last hit is the highest set index.
            for (int i = 0; i < N; i++) begin
                if (pending[i]) sel = W'(i);
            end
        end else begin
            // Candidate order is ptr-1, ptr-2, ... wrapping past 0 to N-1.
            // Scanning from the farthest candidate to the nearest leaves
            // the nearest hit in sel.
            for (int i = N - 1; i >= 0; i--) begin
                int idx;
                idx = (int'(ptr) + 2 * N - 1 - i) % N;
                if (pending[idx]) sel = W'(idx);
            end
        end
    end

    always_comb begin
        clr_vec = '0;
        if (load) clr_vec[sel] = 1'b1;
    end

    // Set is OR-ed in after the clear, so a bit re-requested in the cycle
    // it is granted stays pending and is granted again later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_code  <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_code  <= sel;
            ptr       <= sel;
        end else if (slot_free) begin
            // Nothing to offer: drop valid, keep the last code.
            out_valid <= 1'b0;
        end
    end

    assign any = (|pending) || out_valid;

endmodule

// File: tb/tb_prio_enc_queue.sv
module tb_prio_enc_queue;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic [N-1:0] req = '1;
    logic         out_ready = 1'b1;

    logic         v0, v1, any0, any1;
    logic [W-1:0] c0, c1;
    logic [N-1:0] p0, p1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prio_enc_queue #(.N(N), .MODE(0)) u_fixed (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .out_valid(v0), .out_ready(out_ready), .out_code(c0),
        .pending(p0), .any(any0)
    );

    prio_enc_queue #(.N(N), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .out_valid(v1), .out_ready(out_ready), .out_code(c1),
        .pending(p1), .any(any1)
    );

    typedef struct {
        logic         rst;
        logic         en;
        logic [N-1:0] req;
        logic         rdy;
        logic         v;
        logic [W-1:0] code;
        logic [N-1:0] pend;
        logic         any;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_both(input int idx, input logic v, input logic [W-1:0] code,
                            input logic [N-1:0] pend, input logic an);
        chk("fixed_valid", idx, 64'(v0), 64'(v));
        chk("fixed_code", idx, 64'(c0), 64'(code));
        chk("fixed_pending", idx, 64'(p0), 64'(pend));
        chk("fixed_any", idx, 64'(any0), 64'(an));
        chk("rr_valid", idx, 64'(v1), 64'(v));
        chk("rr_code", idx, 64'(c1), 64'(code));
        chk("rr_pending", idx, 64'(p1), 64'(pend));
        chk("rr_any", idx, 64'(any1), 64'(an));
    endtask

    initial begin
        // Each row: inputs held across one rising edge, expected outputs just after it.
        //              rst   en    req       rdy   v     code  pend      any
        // reset with all requests asserted
        vecs[0]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
        // single-cycle burst drains 7,5,2,0
        vecs[2]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 3'd0, 8'hA5, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 3'd7, 8'h25, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 3'd5, 8'h05, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 3'd2, 8'h01, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
        // stall: 7 offered and frozen while ready is low, then 7 and 4 accepted
        vecs[8]  = '{1'b0, 1'b1, 8'h90, 1'b0, 1'b0, 3'd0, 8'h90, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 3'd7, 8'h10, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 3'd7, 8'h10, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 3'd7, 8'h10, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 3'd7, 8'h10, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 3'd7, 8'h10, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 3'd4, 8'h00, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0};
        // set/clear collision on bit 3: granted twice
        vecs[16] = '{1'b0, 1'b1, 8'h08, 1'b1, 1'b0, 3'd4, 8'h08, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 8'h08, 1'b1, 1'b1, 3'd3, 8'h08, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 3'd3, 8'h00, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0};
        // capture disabled
        vecs[20] = '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0};

        // reset value before the first edge
        #1;
        chk_both(-1, 1'b0, 3'd0, 8'h00, 1'b0);

        for (int i = 0; i < NV; i++) begin
            rst       = vecs[i].rst;
            en        = vecs[i].en;
            req       = vecs[i].req;
            out_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk_both(i, vecs[i].v, vecs[i].code, vecs[i].pend, vecs[i].any);
        end

        // Fairness: req=FF held. Round-robin walks 7..0 and wraps;
        // fixed priority grants 7 on every cycle.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        en = 1'b1;
        req = 8'hFF;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("fair_pending_fixed", 0, 64'(p0), 64'hFF);
        chk("fair_pending_rr", 0, 64'(p1), 64'hFF);
        for (int k = 0; k < 10; k++) begin
            logic [W-1:0] exp_rr;
            exp_rr = W'((7 - k) & 7);
            @(posedge clk);
            #1;
            chk("fair_rr_valid", k, 64'(v1), 64'(1));
            chk("fair_rr_code", k, 64'(c1), 64'(exp_rr));
            chk("fair_fixed_valid", k, 64'(v0), 64'(1));
            chk("fair_fixed_code", k, 64'(c0), 64'(7));
        end

        // Asynchronous reset between edges drops the in-flight grant at once.
        req = 8'h00;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid_fixed", 0, 64'(v0), 64'(0));
        chk("arst_valid_rr", 0, 64'(v1), 64'(0));
        chk("arst_pending_fixed", 0, 64'(p0), 64'h00);
        chk("arst_pending_rr", 0, 64'(p1), 64'h00);
        chk("arst_any_fixed", 0, 64'(any0), 64'(0));
        chk("arst_code_rr", 0, 64'(c1), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_arst_valid", 0, 64'(v0), 64'(0));
        chk("post_arst_any_rr", 0, 64'(any1), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
